fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage for the 9-bit pipelined CPU. It sits directly upstream of the combinational instruction ROM.
- Drives the 16-bit program counter into the ROM and takes back the 9-bit instruction in the same cycle.
- Registers {pc, instruction} into the IF/ID pipeline register for the decoder.
- Handles stalls, branch/jump redirects and the halt opcode.

Parameters:
- RESET_PC, 16'd1: PC value after reset (first program word is at address 1).
- HALT_OP, 5'b11010: opcode field (inst[8:4]) that stops fetch.
- PC_STEP, 16'd1: PC increment per fetched instruction.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC and IF/ID contents (downstream hazard).
- redirect_valid  input  1  taken branch/jump; load redirect_pc.
- redirect_pc  input  16  branch/jump target address.
- pc  output  16  current fetch address to the instruction ROM.
- rom_inst  input  9  instruction returned combinationally by the ROM for pc.
- if_pc  output  16  IF/ID register: address of the held instruction.
- if_inst  output  9  IF/ID register: held instruction.
- if_valid  output  1  IF/ID register holds a real instruction (0 = bubble).
- halted  output  1  fetch stopped on HALT_OP.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: pc=RESET_PC, if_pc=0, if_inst=9'b0, if_valid=0, halted=0, state=RUN.
  - Reset asserted mid-operation overrides everything immediately (async).
- States:
  - RUN: fetching.
  - HALTED: PC frozen, bubbles issued.
- Latency: the ROM is combinational. The instruction at pc is captured into IF/ID on the next rising edge, so there is 1 cycle from pc to if_inst.
- Priority per edge: reset > redirect_valid > stall > halt detect > normal.
- redirect_valid=1 (any state, stall ignored):
  - pc <= redirect_pc; if_valid <= 0; if_inst <= 0; if_pc <= 0.
  - state <= RUN and halted <= 0, so a speculatively fetched halt is squashed.
- stall=1, no redirect: pc, if_pc, if_inst, if_valid and state all hold.
- RUN, no stall/redirect, rom_inst[8:4] != HALT_OP:
  - if_pc <= pc; if_inst <= rom_inst; if_valid <= 1; pc <= pc + PC_STEP.
- RUN, no stall/redirect, rom_inst[8:4] == HALT_OP:
  - The halt is captured like a normal instruction (if_valid <= 1).
  - pc holds (not incremented); state <= HALTED; halted <= 1.
- HALTED, no redirect:
  - pc holds; if_valid <= 0, if_inst <= 0 each cycle (bubbles); halted stays 1.
  - stall in HALTED holds everything.
- PC arithmetic: 16-bit modulo. 16'hFFFF + 1 wraps to 16'h0000; no flag.
- Bubbles: if_inst=0 decodes as add r0. The decoder must qualify on if_valid; fetch always drives 0 with if_valid=0.
- Same edge redirect+halt opcode: redirect wins, halt not recorded.
- pc output is registered; it never changes between edges except on async reset.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds output fetch_count [31:0], reset to 0.
  - Increments on each edge where if_valid is loaded with 1 (halt instruction included).
  - Saturates at 32'hFFFFFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then ROM words 1..3 non-halt, no stall: pc goes 1,2,3,4; if_pc=1,2,3 with if_valid=1 one cycle later; if_inst equals the ROM word each time.
- stall high 2 cycles at pc=5 -> pc stays 5 and if_pc/if_inst/if_valid unchanged for 2 cycles; fetch resumes with if_pc=5.
- redirect_valid=1, redirect_pc=13 while stall=1 at pc=8 -> next cycle pc=13, if_valid=0; following cycle if_pc=13, if_valid=1.
- ROM returns {5'b11010,4'b0000} at pc=14 -> if_pc=14, if_valid=1, halted=1, pc stays 14; subsequent cycles if_valid=0. Then redirect_pc=2 -> halted=0, pc=2, fetch resumes.
- redirect_pc=16'hFFFF with non-halt word -> next pc=16'h0000 (wrap), if_pc=16'hFFFF.
- Assert reset asynchronously mid-run at pc=9 between edges -> pc=1, if_valid=0, halted=0 immediately. With FETCH_PERF_EN: fetch_count=0 after reset and 3 after three valid fetches.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage with IF/ID register, stall, redirect and halt (optional FETCH_PERF_EN)
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'd1,
    parameter logic [4:0]  HALT_OP  = 5'b11010,
    parameter logic [15:0] PC_STEP  = 16'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [15:0] pc,
    input  logic [8:0]  rom_inst,
    output logic [15:0] if_pc,
    output logic [8:0]  if_inst,
    output logic        if_valid,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state, state_n;
    logic [15:0] pc_n;
    logic [15:0] if_pc_n;
    logic [8:0]  if_inst_n;
    logic        if_valid_n;
    logic        halted_n;
    logic        load_valid;

    // Register stage: PC, IF/ID contents and fetch state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            pc       <= RESET_PC;
            if_pc    <= 16'd0;
            if_inst  <= 9'd0;
            if_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            if_pc    <= if_pc_n;
            if_inst  <= if_inst_n;
            if_valid <= if_valid_n;
            halted   <= halted_n;
        end
    end

    // Next-state logic: redirect beats stall, stall beats halt detection.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        if_pc_n    = if_pc;
        if_inst_n  = if_inst;
        if_valid_n = if_valid;
        halted_n   = halted;
        load_valid = 1'b0;
        if (redirect_valid) begin
            // Squashes anything fetched speculatively, including a halt.
            pc_n       = redirect_pc;
            if_pc_n    = 16'd0;
            if_inst_n  = 9'd0;
            if_valid_n = 1'b0;
            state_n    = RUN;
            halted_n   = 1'b0;
        end else if (!stall) begin
            case (state)
                RUN: begin
                    if_pc_n    = pc;
                    if_inst_n  = rom_inst;
                    if_valid_n = 1'b1;
                    load_valid = 1'b1;
                    if (rom_inst[8:4] == HALT_OP) begin
                        state_n  = HALTED;
                        halted_n = 1'b1;
                    end else begin
                        pc_n = pc + PC_STEP;
                    end
                end
                HALTED: begin
                    if_inst_n  = 9'd0;
                    if_valid_n = 1'b0;
                    halted_n   = 1'b1;
                end
                default: begin
                    state_n = RUN;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating count of instructions delivered into IF/ID.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= 32'd0;
        end else if (load_valid && (fetch_count != 32'hFFFF_FFFF)) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'd0;
    logic [15:0] pc;
    logic [8:0]  rom_inst;
    logic [15:0] if_pc;
    logic [8:0]  if_inst;
    logic        if_valid;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
`endif

    int checks = 0;
    int passed = 0;

    fetch_unit dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .pc(pc),
        .rom_inst(rom_inst),
        .if_pc(if_pc),
        .if_inst(if_inst),
        .if_valid(if_valid),
        .halted(halted)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    always #5 clk = ~clk;

    // ROM model: halt word at address 14, otherwise 9'h0A5 ^ pc[8:0].
    always_comb begin
        rom_inst = (pc == 16'd14) ? 9'h1A0 : (9'h0A5 ^ pc[8:0]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_if(input string tag, input logic [15:0] e_pc, input logic [15:0] e_ifpc,
                            input logic [8:0] e_inst, input logic e_valid, input logic e_halt);
        check({tag, ".pc"}, 32'(pc), 32'(e_pc));
        check({tag, ".if_pc"}, 32'(if_pc), 32'(e_ifpc));
        check({tag, ".if_inst"}, 32'(if_inst), 32'(e_inst));
        check({tag, ".if_valid"}, 32'(if_valid), 32'(e_valid));
        check({tag, ".halted"}, 32'(halted), 32'(e_halt));
    endtask

    initial begin
        step();
        step();
        check_if("reset", 16'd1, 16'd0, 9'd0, 1'b0, 1'b0);
`ifdef FETCH_PERF_EN
        check("count_reset", fetch_count, 32'd0);
`endif
        reset = 1'b0;

        // Sequential fetch of words 1..4.
        step(); check_if("seq1", 16'd2, 16'd1, 9'h0A4, 1'b1, 1'b0);
        step(); check_if("seq2", 16'd3, 16'd2, 9'h0A7, 1'b1, 1'b0);
        step(); check_if("seq3", 16'd4, 16'd3, 9'h0A6, 1'b1, 1'b0);
`ifdef FETCH_PERF_EN
        check("count3", fetch_count, 32'd3);
`endif
        step(); check_if("seq4", 16'd5, 16'd4, 9'h0A1, 1'b1, 1'b0);

        // Two stall cycles at pc=5.
        stall = 1'b1;
        step(); check_if("stall1", 16'd5, 16'd4, 9'h0A1, 1'b1, 1'b0);
        step(); check_if("stall2", 16'd5, 16'd4, 9'h0A1, 1'b1, 1'b0);
        stall = 1'b0;
        step(); check_if("resume", 16'd6, 16'd5, 9'h0A0, 1'b1, 1'b0);
        step();
        step(); check_if("at8", 16'd8, 16'd7, 9'h0A2, 1'b1, 1'b0);

        // Redirect while stalled.
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'd13;
        step(); check_if("redir", 16'd13, 16'd0, 9'd0, 1'b0, 1'b0);
        stall = 1'b0; redirect_valid = 1'b0;
        step(); check_if("redir_f", 16'd14, 16'd13, 9'h0A8, 1'b1, 1'b0);

        // Halt word at pc=14.
        step(); check_if("halt", 16'd14, 16'd14, 9'h1A0, 1'b1, 1'b1);
        step(); check_if("bubble", 16'd14, 16'd14, 9'd0, 1'b0, 1'b1);
        stall = 1'b1;
        step(); check_if("halt_stall", 16'd14, 16'd14, 9'd0, 1'b0, 1'b1);
        stall = 1'b0;

        // Redirect out of halt on the same edge the ROM shows the halt word.
        redirect_valid = 1'b1; redirect_pc = 16'd2;
        step(); check_if("unhalt", 16'd2, 16'd0, 9'd0, 1'b0, 1'b0);
        redirect_valid = 1'b0;
        step(); check_if("unhalt_f", 16'd3, 16'd2, 9'h0A7, 1'b1, 1'b0);

        // PC wrap at 16'hFFFF.
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
        step(); check_if("wrap_r", 16'hFFFF, 16'd0, 9'd0, 1'b0, 1'b0);
        redirect_valid = 1'b0;
        step(); check_if("wrap", 16'h0000, 16'hFFFF, 9'h15A, 1'b1, 1'b0);

        // Asynchronous reset between edges at pc=9.
        redirect_valid = 1'b1; redirect_pc = 16'd8;
        step();
        redirect_valid = 1'b0;
        step(); check_if("pre_rst", 16'd9, 16'd8, 9'h0AD, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 check_if("async_rst", 16'd1, 16'd0, 9'd0, 1'b0, 1'b0);
`ifdef FETCH_PERF_EN
        check("count_rst2", fetch_count, 32'd0);
`endif
        reset = 1'b0;
        step(); step(); step();
        check_if("after_rst", 16'd4, 16'd3, 9'h0A6, 1'b1, 1'b0);
`ifdef FETCH_PERF_EN
        check("count3b", fetch_count, 32'd3);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
